// File: rtl/red_pitaya_dac_eq.sv
// red_pitaya_dac_eq: DAC equalizer (pre-emphasis, one-pole IIR, gain) with shadow
// coefficients; define DAC_EQ_SAT_CNT_EN to build the saturation counter.
module red_pitaya_dac_eq #(
    parameter int FLUSH_LEN = 8
) (
    input  logic               dac_clk_i,
    input  logic               dac_rstn_i,
    input  logic signed [13:0] dac_dat_i,
    output logic signed [13:0] dac_dat_o,
    input  logic signed [17:0] cfg_aa_i,
    input  logic signed [24:0] cfg_bb_i,
    input  logic signed [24:0] cfg_kk_i,
    input  logic               cfg_upd_i,
    output logic               cfg_busy_o,
    input  logic               sat_clr_i,
    output logic        [15:0] sat_cnt_o
);

    localparam int CW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FLUSH_LEN - 1);

    localparam logic signed [41:0] R_MAX = 42'sd8388607;
    localparam logic signed [41:0] R_MIN = -42'sd8388608;
    localparam logic signed [48:0] Y_MAX = 49'sd8191;
    localparam logic signed [48:0] Y_MIN = -49'sd8192;

    typedef enum logic [1:0] {RUN, LATCH, FLUSH} state_t;

    state_t        state;
    logic [CW-1:0] flush_cnt;
    logic          hold;

    logic signed [17:0] aa_sh;
    logic signed [24:0] bb_sh;
    logic signed [24:0] kk_sh;

    logic signed [13:0] x1;
    logic signed [13:0] xp1;
    logic signed [13:0] x2;
    logic signed [39:0] p2;
    logic signed [20:0] s3;
    logic signed [23:0] r4;
    logic signed [48:0] g5;

    logic        [14:0] d2;
    logic signed [39:0] d_w;
    logic signed [39:0] bb_w;
    logic signed [39:0] p_nxt;
    logic signed [39:0] x_w;
    logic signed [39:0] s_full;
    logic signed [41:0] aa_w;
    logic signed [41:0] rf_w;
    logic signed [41:0] ar;
    logic signed [41:0] s_w;
    logic signed [41:0] r_full;
    logic signed [23:0] r_nxt;
    logic signed [48:0] r_w;
    logic signed [48:0] kk_w;
    logic signed [48:0] g_nxt;
    logic signed [48:0] g_sh;
    logic signed [13:0] y_nxt;
    logic               sat_evt;
    logic               unused_s_hi;

    // Datapath registers are forced to zero on every cycle that will be busy.
    always_comb begin
        hold = 1'b0;
        unique case (state)
            RUN:     hold = cfg_upd_i;
            LATCH:   hold = 1'b1;
            FLUSH:   hold = (flush_cnt != CNT_LAST);
            default: hold = 1'b0;
        endcase
    end

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            state      <= RUN;
            flush_cnt  <= '0;
            cfg_busy_o <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (cfg_upd_i) begin
                        state      <= LATCH;
                        cfg_busy_o <= 1'b1;
                    end
                end
                LATCH: begin
                    state     <= FLUSH;
                    flush_cnt <= '0;
                end
                FLUSH: begin
                    if (flush_cnt == CNT_LAST) begin
                        state      <= RUN;
                        cfg_busy_o <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt + CW'(1);
                    end
                end
                default: begin
                    state      <= RUN;
                    cfg_busy_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            aa_sh <= '0;
            bb_sh <= '0;
            kk_sh <= 25'sh100000;
        end else if (state == LATCH) begin
            aa_sh <= cfg_aa_i;
            bb_sh <= cfg_bb_i;
            kk_sh <= cfg_kk_i;
        end
    end

    assign d2     = {x1[13], x1} - {xp1[13], xp1};
    assign d_w    = $signed({{25{d2[14]}}, d2});
    assign bb_w   = $signed({{15{bb_sh[24]}}, bb_sh});
    assign p_nxt  = d_w * bb_w;

    assign x_w    = $signed({{26{x2[13]}}, x2});
    assign s_full = x_w + (p2 >>> 20);
    assign unused_s_hi = ^s_full[39:21];

    assign aa_w   = $signed({{24{aa_sh[17]}}, aa_sh});
    assign rf_w   = $signed({{18{r4[23]}}, r4});
    assign ar     = aa_w * rf_w;
    assign s_w    = $signed({{21{s3[20]}}, s3});
    assign r_full = s_w + (ar >>> 17);

    always_comb begin
        r_nxt = r_full[23:0];
        if (r_full > R_MAX) begin
            r_nxt = 24'h7f_ffff;
        end else if (r_full < R_MIN) begin
            r_nxt = 24'h80_0000;
        end
    end

    assign r_w   = $signed({{25{r4[23]}}, r4});
    assign kk_w  = $signed({{24{kk_sh[24]}}, kk_sh});
    assign g_nxt = r_w * kk_w;
    assign g_sh  = g5 >>> 20;

    always_comb begin
        y_nxt   = g_sh[13:0];
        sat_evt = 1'b0;
        if (g_sh > Y_MAX) begin
            y_nxt   = 14'h1fff;
            sat_evt = 1'b1;
        end else if (g_sh < Y_MIN) begin
            y_nxt   = 14'h2000;
            sat_evt = 1'b1;
        end
    end

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            x1        <= '0;
            xp1       <= '0;
            x2        <= '0;
            p2        <= '0;
            s3        <= '0;
            r4        <= '0;
            g5        <= '0;
            dac_dat_o <= '0;
        end else if (hold) begin
            x1        <= '0;
            xp1       <= '0;
            x2        <= '0;
            p2        <= '0;
            s3        <= '0;
            r4        <= '0;
            g5        <= '0;
            dac_dat_o <= '0;
        end else begin
            x1        <= dac_dat_i;
            xp1       <= x1;
            x2        <= x1;
            p2        <= p_nxt;
            s3        <= s_full[20:0];
            r4        <= r_nxt;
            g5        <= g_nxt;
            dac_dat_o <= y_nxt;
        end
    end

`ifdef DAC_EQ_SAT_CNT_EN
    logic [15:0] sat_cnt;

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            sat_cnt <= '0;
        end else if (sat_clr_i) begin
            sat_cnt <= '0;
        end else if (sat_evt && !hold && !cfg_busy_o
                     && (sat_cnt != 16'hffff)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

    assign sat_cnt_o = sat_cnt;
`else
    logic unused_sat;

    assign unused_sat = sat_clr_i ^ sat_evt;
    assign sat_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_red_pitaya_dac_eq.sv
// tb_red_pitaya_dac_eq: randomized self-checking bench for red_pitaya_dac_eq
// against an integer reference model of the equalizer.
module tb_red_pitaya_dac_eq;

    logic               dac_clk_i  = 1'b0;
    logic               dac_rstn_i = 1'b1;
    logic signed [13:0] dac_dat_i  = '0;
    logic signed [13:0] dac_dat_o;
    logic signed [17:0] cfg_aa_i   = '0;
    logic signed [24:0] cfg_bb_i   = '0;
    logic signed [24:0] cfg_kk_i   = 25'h100000;
    logic               cfg_upd_i  = 1'b0;
    logic               cfg_busy_o;
    logic               sat_clr_i  = 1'b0;
    logic        [15:0] sat_cnt_o;

    int total = 0;
    int bad   = 0;

    longint      m_aa, m_bb, m_kk, m_xp, m_r;
    int          exp_q[$];
    bit          sat_q[$];
    logic [15:0] exp_cnt = '0;
    bit          clr_prev = 1'b0;

    red_pitaya_dac_eq #(.FLUSH_LEN(8)) dut (
        .dac_clk_i (dac_clk_i),
        .dac_rstn_i(dac_rstn_i),
        .dac_dat_i (dac_dat_i),
        .dac_dat_o (dac_dat_o),
        .cfg_aa_i  (cfg_aa_i),
        .cfg_bb_i  (cfg_bb_i),
        .cfg_kk_i  (cfg_kk_i),
        .cfg_upd_i (cfg_upd_i),
        .cfg_busy_o(cfg_busy_o),
        .sat_clr_i (sat_clr_i),
        .sat_cnt_o (sat_cnt_o)
    );

    always #5 dac_clk_i = ~dac_clk_i;

    // Equalizer output for one new sample, straight from the transfer rules.
    task automatic model_push(input int x);
        longint d, s, r, y;
        d = longint'(x) - m_xp;
        s = longint'(x) + ((d * m_bb) >>> 20);
        r = s + ((m_aa * m_r) >>> 17);
        if (r > 8388607) r = 8388607;
        else if (r < -8388608) r = -8388608;
        y = (r * m_kk) >>> 20;
        sat_q.push_back(y > 8191 || y < -8192);
        if (y > 8191) y = 8191;
        else if (y < -8192) y = -8192;
        exp_q.push_back(int'(y));
        m_xp = longint'(x);
        m_r  = r;
    endtask

    task automatic model_restart(input int aa, input int bb, input int kk);
        m_aa = aa; m_bb = bb; m_kk = kk;
        m_xp = 0;  m_r = 0;
        exp_q.delete();
        sat_q.delete();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(0);
            sat_q.push_back(1'b0);
        end
    endtask

    // Advance to the next falling edge, return the expected outputs there,
    // then drive the next sample.
    task automatic tick(input int x, input bit clr,
                        output logic signed [13:0] ey,
                        output logic [15:0] ec);
        int y;
        bit s;
        @(negedge dac_clk_i);
        y = exp_q.pop_front();
        s = sat_q.pop_front();
`ifdef DAC_EQ_SAT_CNT_EN
        if (clr_prev) exp_cnt = '0;
        else if (s && exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
`else
        if (s) exp_cnt = '0;
        exp_cnt = '0;
`endif
        ey = 14'(y);
        ec = exp_cnt;
        dac_dat_i = 14'(x);
        sat_clr_i = clr;
        clr_prev  = clr;
        model_push(x);
    endtask

    task automatic scramble_cfg();
        cfg_aa_i = 18'($urandom);
        cfg_bb_i = 25'($urandom);
        cfg_kk_i = 25'($urandom);
    endtask

    task automatic do_update(input int aa, input int bb, input int kk,
                             input bit dbl, output int nb, output bit nz);
        logic signed [13:0] ey;
        logic [15:0] ec;
        int guard;
        tick(0, 1'b0, ey, ec);
        cfg_aa_i  = 18'(aa);
        cfg_bb_i  = 25'(bb);
        cfg_kk_i  = 25'(kk);
        cfg_upd_i = 1'b1;
        @(negedge dac_clk_i);
        cfg_upd_i = 1'b0;
        nb = 0; nz = 1'b0; guard = 0;
        while (cfg_busy_o === 1'b1 && guard < 64) begin
            nb++;
            if (dac_dat_o !== 14'sd0) nz = 1'b1;
            cfg_upd_i = dbl && (nb == 3);
            if (nb >= 2) scramble_cfg();
            @(negedge dac_clk_i);
            guard++;
        end
        cfg_upd_i = 1'b0;
        model_restart(aa, bb, kk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge dac_clk_i);
        total++;
        if (dac_dat_o !== 14'sd0) begin
            bad++; $display("FAIL reset_dat got=%0d exp=0", dac_dat_o);
        end
        total++;
        if (cfg_busy_o !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b exp=0", cfg_busy_o);
        end
        total++;
        if (sat_cnt_o !== 16'd0) begin
            bad++; $display("FAIL reset_cnt got=%0d exp=0", sat_cnt_o);
        end
        dac_rstn_i = 1'b1;
        exp_cnt = '0; clr_prev = 1'b0;
        model_restart(0, 0, 1 << 20);
    endtask

    task automatic test_step();
        logic signed [13:0] ey;
        logic [15:0] ec;
        int first;
        first = -1;
        for (int i = 0; i < 16; i++) begin
            tick((i < 4) ? 0 : 1000, 1'b0, ey, ec);
            total++;
            if (dac_dat_o !== ey) begin
                bad++; $display("FAIL step_dat got=%0d exp=%0d", dac_dat_o, ey);
            end
            if (first < 0 && dac_dat_o == 14'sd1000) first = i - 4;
        end
        total++;
        if (first != 6) begin
            bad++; $display("FAIL step_latency got=%0d exp=6", first);
        end
    endtask

    task automatic test_preemph();
        logic signed [13:0] ey;
        logic [15:0] ec;
        int nb, n2k;
        bit nz;
        do_update(0, 1 << 20, 1 << 20, 1'b0, nb, nz);
        total++;
        if (nb != 9 || nz) begin
            bad++; $display("FAIL pre_busy got=%0d/%0b exp=9/0", nb, nz);
        end
        n2k = 0;
        for (int i = 0; i < 18; i++) begin
            tick((i < 4) ? 0 : 1000, 1'b0, ey, ec);
            total++;
            if (dac_dat_o !== ey) begin
                bad++; $display("FAIL pre_dat got=%0d exp=%0d", dac_dat_o, ey);
            end
            if (dac_dat_o == 14'sd2000) n2k++;
        end
        total++;
        if (n2k != 1) begin
            bad++; $display("FAIL pre_peak got=%0d exp=1", n2k);
        end
    endtask

    task automatic test_sat();
        logic signed [13:0] ey;
        logic [15:0] ec;
        int nb;
        bit nz;
        do_update(0, 0, 2 << 20, 1'b0, nb, nz);
        for (int i = 0; i < 14; i++) begin
            tick(8000, (i == 10), ey, ec);
            total++;
            if (dac_dat_o !== ey) begin
                bad++; $display("FAIL sat_dat got=%0d exp=%0d", dac_dat_o, ey);
            end
            total++;
            if (sat_cnt_o !== ec) begin
                bad++; $display("FAIL sat_cnt got=%0d exp=%0d", sat_cnt_o, ec);
            end
`ifdef DAC_EQ_SAT_CNT_EN
            if (i == 11) begin
                total++;
                if (sat_cnt_o !== 16'd0) begin
                    bad++; $display("FAIL sat_clr got=%0d exp=0", sat_cnt_o);
                end
            end
`endif
        end
        total++;
        if (dac_dat_o !== 14'sd8191) begin
            bad++; $display("FAIL sat_clamp got=%0d exp=8191", dac_dat_o);
        end
    endtask

    task automatic test_busy_double();
        int nb;
        bit nz;
        do_update(0, 0, 1 << 20, 1'b1, nb, nz);
        total++;
        if (nb != 9) begin
            bad++; $display("FAIL dbl_busy got=%0d exp=9", nb);
        end
        total++;
        if (nz) begin
            bad++; $display("FAIL dbl_zero got=%0b exp=0", nz);
        end
    endtask

    task automatic test_random();
        logic signed [13:0] ey;
        logic [15:0] ec;
        int nb, aa, bb, kk;
        bit nz;
        for (int r = 0; r < 3; r++) begin
            aa = int'($urandom_range(0, 235928)) - 117964;
            bb = int'($urandom_range(0, 1 << 22)) - (1 << 21);
            kk = int'($urandom_range(1 << 18, 3 << 20));
            do_update(aa, bb, kk, 1'b0, nb, nz);
            total++;
            if (nb != 9) begin
                bad++; $display("FAIL rnd_busy got=%0d exp=9", nb);
            end
            for (int i = 0; i < 150; i++) begin
                scramble_cfg();
                tick(int'($urandom_range(0, 16383)) - 8192,
                     ($urandom_range(0, 19) == 0), ey, ec);
                total++;
                if (dac_dat_o !== ey) begin
                    bad++; $display("FAIL rnd_dat got=%0d exp=%0d", dac_dat_o, ey);
                end
                total++;
                if (sat_cnt_o !== ec) begin
                    bad++; $display("FAIL rnd_cnt got=%0d exp=%0d", sat_cnt_o, ec);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic signed [13:0] ey;
        logic [15:0] ec;
        int nb1, nb2;
        bit nz1, nz2;
        do_update(0, 0, 3 << 20, 1'b0, nb1, nz1);
        do_update(0, 1 << 19, 1 << 20, 1'b0, nb2, nz2);
        total++;
        if (nb1 != 9 || nb2 != 9) begin
            bad++; $display("FAIL b2b_busy got=%0d,%0d exp=9,9", nb1, nb2);
        end
        for (int i = 0; i < 30; i++) begin
            tick(int'($urandom_range(0, 8191)) - 4096, 1'b0, ey, ec);
            total++;
            if (dac_dat_o !== ey) begin
                bad++; $display("FAIL b2b_dat got=%0d exp=%0d", dac_dat_o, ey);
            end
        end
    endtask

    task automatic test_reset_flush();
        logic signed [13:0] ey;
        logic [15:0] ec;
        tick(0, 1'b0, ey, ec);
        cfg_aa_i  = '0;
        cfg_bb_i  = '0;
        cfg_kk_i  = 25'h300000;
        cfg_upd_i = 1'b1;
        @(negedge dac_clk_i);
        cfg_upd_i = 1'b0;
        repeat (4) @(negedge dac_clk_i);
        total++;
        if (cfg_busy_o !== 1'b1) begin
            bad++; $display("FAIL rf_busy_pre got=%b exp=1", cfg_busy_o);
        end
        #2 dac_rstn_i = 1'b0;
        #1;
        total++;
        if (cfg_busy_o !== 1'b0) begin
            bad++; $display("FAIL rf_busy got=%b exp=0", cfg_busy_o);
        end
        total++;
        if (dac_dat_o !== 14'sd0 || sat_cnt_o !== 16'd0) begin
            bad++;
            $display("FAIL rf_out got=%0d/%0d exp=0/0", dac_dat_o, sat_cnt_o);
        end
        @(negedge dac_clk_i);
        dac_rstn_i = 1'b1;
        exp_cnt = '0; clr_prev = 1'b0;
        model_restart(0, 0, 1 << 20);
        for (int i = 0; i < 30; i++) begin
            tick(int'($urandom_range(0, 16383)) - 8192, 1'b0, ey, ec);
            total++;
            if (dac_dat_o !== ey) begin
                bad++; $display("FAIL rf_dat got=%0d exp=%0d", dac_dat_o, ey);
            end
        end
    endtask

    initial begin
        #2 dac_rstn_i = 1'b0;
        test_reset();
        test_step();
        test_preemph();
        test_sat();
        test_busy_double();
        test_random();
        test_back_to_back();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/red_pitaya_dac_eq.md
RED_PITAYA_DAC_EQ -- requirements
Module: red_pitaya_dac_eq

Interface
REQ-001 Parameter: FLUSH_LEN, default 8, number of dac_clk_i cycles the pipeline is flushed after a coefficient update.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 dac_clk_i  in  1  DAC clock; the only clock.
REQ-004 dac_rstn_i  in  1  DAC reset, asynchronous, active-low.
REQ-005 dac_dat_i  in  14  signed input sample, one per cycle.
REQ-006 dac_dat_o  out  14  signed equalized sample to the DAC.
REQ-007 cfg_aa_i  in  18  signed IIR pole coefficient, Q1.17.
REQ-008 cfg_bb_i  in  25  signed pre-emphasis coefficient, Q5.20.
REQ-009 cfg_kk_i  in  25  signed gain coefficient, Q5.20.
REQ-010 cfg_upd_i  in  1  single-cycle coefficient update request.
REQ-011 cfg_busy_o  out  1  high while an update is in progress.
REQ-012 sat_clr_i  in  1  synchronous clear of the saturation counter.
REQ-013 sat_cnt_o  out  16  count of saturated output samples.

Function
REQ-014 Working coefficients SHALL be shadow registers; the cfg_*_i ports SHALL affect the datapath only through an update.
REQ-015 The FSM SHALL have states RUN, LATCH and FLUSH; reset state RUN.
REQ-016 RUN -> LATCH on cfg_upd_i=1; LATCH lasts 1 cycle and captures all three cfg_*_i into the shadows; LATCH -> FLUSH.
REQ-017 FLUSH SHALL last exactly FLUSH_LEN cycles, then go to RUN.
REQ-018 cfg_busy_o SHALL be high in LATCH and FLUSH (FLUSH_LEN+1 cycles) and low in RUN.
REQ-019 A cfg_upd_i asserted while cfg_busy_o=1 SHALL be ignored, with no queuing.
REQ-020 During FLUSH, all datapath registers SHALL be held at 0 and dac_dat_o SHALL be 0.
REQ-021 Stage 1 SHALL register x[n]=dac_dat_i and x[n-1].
REQ-022 Stage 2 SHALL compute d=x[n]-x[n-1] (15-bit) and p=d*BB (40-bit).
REQ-023 Stage 3 SHALL compute s=x+(p>>>20), held in 21 bits.
REQ-024 Stage 4 SHALL compute r[n]=s+((AA*r[n-1])>>>17) with a single-cycle feedback loop; r is 24-bit signed, saturated to the 24-bit range.
REQ-025 Stage 5 SHALL compute g=r*KK (49-bit).
REQ-026 Stage 6 SHALL register sat14(g>>>20) to dac_dat_o.
REQ-027 All arithmetic SHALL be signed two's complement; every >>> SHALL truncate toward minus infinity.
REQ-028 sat14 SHALL clamp to +8191 / -8192.
REQ-029 Latency from dac_dat_i to dac_dat_o SHALL be exactly 6 cycles in RUN.
REQ-030 Stage 6 SHALL flag a clamped sample as a saturation event.

Reset
REQ-031 On dac_rstn_i=0, the block SHALL immediately set, asynchronously: dac_dat_o=0, cfg_busy_o=0, sat_cnt_o=0, FSM=RUN, all datapath registers 0.
REQ-032 On dac_rstn_i=0, the shadows SHALL reset to AA=0, BB=0 and KK=0x100000 (unity gain).
REQ-033 Reset asserted during LATCH or FLUSH SHALL abort the update, and the shadows SHALL take their reset values.

Configuration
REQ-034 The macro DAC_EQ_SAT_CNT_EN SHALL control the saturation counter.
REQ-035 With DAC_EQ_SAT_CNT_EN defined: sat_cnt_o increments once per saturation event.
REQ-036 The counter SHALL saturate at 0xFFFF.
REQ-037 sat_clr_i SHALL zero the counter the next cycle and take priority over a simultaneous event.
REQ-038 The counter SHALL not count during FLUSH.
REQ-039 Without DAC_EQ_SAT_CNT_EN: sat_cnt_o SHALL be constant 0, sat_clr_i SHALL be ignored, and no counter logic SHALL be present.

Verification
REQ-040 After reset (AA=0, BB=0, KK=unity), step dac_dat_i 0 -> 1000 -> dac_dat_o = 1000 exactly 6 cycles later, then constant.
REQ-041 Update to BB=0x100000, AA=0, KK=0x100000, then step 0 -> 1000 -> dac_dat_o one sample of 2000, then 1000.
REQ-042 Update to KK=0x200000, input 8000 -> dac_dat_o=8191.
REQ-043 Continuing REQ-042 (DAC_EQ_SAT_CNT_EN defined): sat_cnt_o +1 per sample; sat_clr_i pulse -> 0 the next cycle.
REQ-044 cfg_upd_i pulse with FLUSH_LEN=8 -> cfg_busy_o high 9 cycles and dac_dat_o=0 throughout; a second pulse during busy -> no extra busy cycles.
REQ-045 dac_rstn_i low mid-FLUSH -> cfg_busy_o=0 and dac_dat_o=0 immediately, without a clock edge; after release, KK is unity.
